// File: rtl/serial_byte_loader_pkg.sv
// Shared types and helpers for the serial byte loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package common;

    typedef enum logic {
        LD_IDLE  = 1'b0,
        LD_SHIFT = 1'b1
    } loader_state_t;

    // Ceiling log2. Returns 0 for v <= 1. Used to size counters from parameters.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_byte_loader_shift.sv
// Shift register plus bit counter; flags the edge that captures the last bit of a word.
// Latency: word is presented combinationally on the completion edge (includes current SER).
// Backpressure: none; every SHIFT_EN edge is accepted, ABORT wins over SHIFT_EN.
//
// Ports: CP clock, MR async active-high reset, SER serial bit, SHIFT_EN capture enable,
//        ABORT drop partial word; sh registered shift contents, word assembled word
//        including this edge's SER, count bits held so far, done completion this edge.
module serial_byte_loader_shift
    import common::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = clog2(WIDTH + 1)
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             SER,
    input  logic             SHIFT_EN,
    input  logic             ABORT,
    output logic [WIDTH-1:0] sh,
    output logic [WIDTH-1:0] word,
    output logic [CW-1:0]    count,
    output logic             done
);

    logic last_bit;

    always_comb begin
        word = sh;
        if (MSB_FIRST) begin
            word = {sh[WIDTH-2:0], SER};
        end else begin
            word = {SER, sh[WIDTH-1:1]};
        end
    end

    assign last_bit = (count == CW'(WIDTH - 1));
    assign done     = SHIFT_EN && !ABORT && last_bit;

    // On ABORT the shift contents are left alone: the next word shifts in WIDTH
    // fresh bits, which fully displaces whatever was there.
    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            sh    <= '0;
            count <= '0;
        end else if (ABORT) begin
            count <= '0;
        end else if (SHIFT_EN) begin
            sh    <= word;
            count <= last_bit ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_byte_loader.sv
// Serial-in/parallel-out loader with a level STB / ACK handshake and sticky overrun flag.
// Latency: Q/STB valid right after the edge capturing bit WIDTH; no extra stage.
// Backpressure: a word completing while STB=1 and ACK=0 is dropped and sets OVR.
//
// Ports: CP clock, MR async active-high reset, SER/SHIFT_EN serial input, ABORT drop
//        partial word, ACK consume Q; Q last word, STB word valid, BUSY partial word
//        in progress, OVR sticky overrun.
module serial_byte_loader
    import common::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             SER,
    input  logic             SHIFT_EN,
    input  logic             ABORT,
    input  logic             ACK,
    output logic [WIDTH-1:0] Q,
    output logic             STB,
    output logic             BUSY,
    output logic             OVR
);

    localparam int CW = clog2(WIDTH + 1);

    loader_state_t    state;
    loader_state_t    state_nxt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    count;
    logic             done;
    logic             unused_dbg;

    serial_byte_loader_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CW        (CW)
    ) u_shift (
        .CP       (CP),
        .MR       (MR),
        .SER      (SER),
        .SHIFT_EN (SHIFT_EN),
        .ABORT    (ABORT),
        .sh       (sh),
        .word     (word),
        .count    (count),
        .done     (done)
    );

    // Raw shift contents and count are observation-only at this level.
    assign unused_dbg = ^{sh, count};

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            state <= LD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (ABORT) begin
            state_nxt = LD_IDLE;
        end else if (SHIFT_EN) begin
            case (state)
                LD_IDLE:  state_nxt = LD_SHIFT;
                LD_SHIFT: state_nxt = done ? LD_IDLE : LD_SHIFT;
                default:  state_nxt = LD_IDLE;
            endcase
        end
    end

    assign BUSY = (state == LD_SHIFT);

    // ACK on the completion edge frees the slot for the new word in the same cycle.
    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            Q   <= '0;
            STB <= 1'b0;
            OVR <= 1'b0;
        end else if (done) begin
            if (!STB || ACK) begin
                Q   <= word;
                STB <= 1'b1;
            end else begin
                OVR <= 1'b1;
            end
        end else if (ACK) begin
            STB <= 1'b0;
        end
    end

`ifdef FORMAL
    logic f_past;

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            f_past <= 1'b0;
        end else begin
            f_past <= 1'b1;
        end
    end

    always_comb begin
        if (MR) begin
            assert (Q == '0 && !STB && !BUSY && !OVR);
        end
    end

    a_stb_hold: assert property (@(posedge CP) disable iff (MR)
        (f_past && $past(STB) && !$past(ACK)) |-> STB);

    a_q_stable: assert property (@(posedge CP) disable iff (MR)
        (f_past && $past(STB) && !$past(ACK)) |-> (Q == $past(Q)));

    a_count_rng: assert property (@(posedge CP) disable iff (MR)
        count < CW'(WIDTH));
`endif

endmodule

// File: tb/tb_serial_byte_loader.sv
module tb_serial_byte_loader;

    logic       CP;
    logic       MR;
    logic       SER;
    logic       SHIFT_EN;
    logic       ABORT;
    logic       ACK;
    logic [7:0] q_m, q_l;
    logic       stb_m, stb_l, busy_m, busy_l, ovr_m, ovr_l;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic       ser;
        logic       se;
        logic       ab;
        logic       ack;
        logic [7:0] qm;
        logic [7:0] ql;
        logic       stb;
        logic       busy;
        logic       ovr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .CP(CP), .MR(MR), .SER(SER), .SHIFT_EN(SHIFT_EN), .ABORT(ABORT), .ACK(ACK),
        .Q(q_m), .STB(stb_m), .BUSY(busy_m), .OVR(ovr_m)
    );

    serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .CP(CP), .MR(MR), .SER(SER), .SHIFT_EN(SHIFT_EN), .ABORT(ABORT), .ACK(ACK),
        .Q(q_l), .STB(stb_l), .BUSY(busy_l), .OVR(ovr_l)
    );

    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7 - i];
        return r;
    endfunction

    function void add(input logic ser, se, ab, ack, input logic [7:0] qm, ql,
                      input logic stb, busy, ovr);
        vec_t v;
        v.ser = ser; v.se = se; v.ab = ab; v.ack = ack;
        v.qm = qm; v.ql = ql; v.stb = stb; v.busy = busy; v.ovr = ovr;
        vecs.push_back(v);
    endfunction

    // One word, MSB-of-w sent first. Outputs hold the "mid" values until the
    // completion edge; an optional SHIFT_EN=0 hold cycle follows the 4th bit.
    function void add_word(input logic [7:0] w, input logic ack_last, input logic gap,
                           input logic [7:0] mq, input logic mstb, movr,
                           input logic [7:0] eq, input logic estb, eovr);
        for (int i = 7; i >= 0; i--) begin
            if (i > 0) add(w[i], 1'b1, 1'b0, 1'b0, mq, rev8(mq), mstb, 1'b1, movr);
            else       add(w[i], 1'b1, 1'b0, ack_last, eq, rev8(eq), estb, 1'b0, eovr);
            if (gap && i == 4) add(1'b1, 1'b0, 1'b0, 1'b0, mq, rev8(mq), mstb, 1'b1, movr);
        end
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called on CP low: drive, push expectation, sample 1 time unit after the rise.
    task automatic run_vecs(input string tag);
        vec_t v, e;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            SER = v.ser; SHIFT_EN = v.se; ABORT = v.ab; ACK = v.ack;
            sb.push_back(v);
            @(posedge CP);
            #1;
            e = sb.pop_front();
            chk($sformatf("%s[%0d].q_msb", tag, i), q_m, e.qm);
            chk($sformatf("%s[%0d].q_lsb", tag, i), q_l, e.ql);
            chk($sformatf("%s[%0d].stb", tag, i), {6'd0, stb_m, stb_l}, {6'd0, e.stb, e.stb});
            chk($sformatf("%s[%0d].busy", tag, i), {6'd0, busy_m, busy_l}, {6'd0, e.busy, e.busy});
            chk($sformatf("%s[%0d].ovr", tag, i), {6'd0, ovr_m, ovr_l}, {6'd0, e.ovr, e.ovr});
            @(negedge CP);
        end
        SHIFT_EN = 1'b0; ABORT = 1'b0; ACK = 1'b0; SER = 1'b0;
        vecs.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".q_msb"}, q_m, 8'h00);
        chk({tag, ".q_lsb"}, q_l, 8'h00);
        chk({tag, ".stb"},  {6'd0, stb_m, stb_l}, 8'h00);
        chk({tag, ".busy"}, {6'd0, busy_m, busy_l}, 8'h00);
        chk({tag, ".ovr"},  {6'd0, ovr_m, ovr_l}, 8'h00);
    endtask

    initial begin
        MR = 1'b1; SER = 1'b0; SHIFT_EN = 1'b0; ABORT = 1'b0; ACK = 1'b0;
        #2;
        chk_zero("reset");
        @(negedge CP);
        MR = 1'b0;

        // Stream 0,0,0,1,0,0,1,0: 8'h12 MSB-first, 8'h48 LSB-first; then ACK.
        add_word(8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 8'h48, 1'b0, 1'b0, 1'b0);
        // Overrun: A5 then 3C with no ACK keeps A5 and sets OVR; ACK leaves OVR set.
        add_word(8'hA5, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
        add_word(8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1);
        // STB=1 holding FF, then 4 bits of a partial word.
        add_word(8'hFF, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
        run_vecs("seqA");

        // MR during CP low: outputs clear before any edge.
        MR = 1'b1;
        #1;
        chk_zero("mr_async");
        #2;
        MR = 1'b0;

        // Word after reset release assembles cleanly.
        add_word(8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 8'h48, 1'b0, 1'b0, 1'b0);
        // ACK on the completion edge replaces A5 with 3C, no overrun.
        add_word(8'hA5, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
        add_word(8'h3C, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0);
        // ABORT together with SHIFT_EN after 5 bits; then a full word.
        for (int i = 0; i < 5; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0);
        add_word(8'h6B, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h6B, 1'b1, 1'b0);
        // Back-to-back: next word starts on the edge after completion.
        add_word(8'h81, 1'b1, 1'b1, 8'h6B, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0);
        // ACK with STB=0 is ignored.
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0);
        run_vecs("seqB");

        if (sb.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/serial_byte_loader.md
# serial_byte_loader

Serial-in/parallel-out loader that assembles a serial bit stream into a WIDTH-bit word and presents it, with a valid/acknowledge handshake, to the downstream 8-bit clearable holding register's data inputs. It sits directly upstream of that register. Its STB output, qualified with the system clock, loads the register. Single clock domain; all datapath activity is on CP rising edges.

## Interface
- WIDTH, 8, number of bits per word (2..32).
- MSB_FIRST, 1, 1: the first serial bit lands in Q[WIDTH-1]; 0: the first bit lands in Q[0].

- CP  in  1  clock; rising edge active.
- MR  in  1  master reset; asynchronous, active-high. Clears all state immediately.
- SER  in  1  serial data; sampled on CP rise when SHIFT_EN=1.
- SHIFT_EN  in  1  when high, SER is captured this edge.
- ABORT  in  1  discards the partial word this edge.
- ACK  in  1  downstream consumed Q; clears STB.
- Q  out  WIDTH  last completed word; stable while STB=1.
- STB  out  1  word valid; level, held until ACK.
- BUSY  out  1  partial word in progress (bit count != 0).
- OVR  out  1  sticky overrun flag; cleared only by MR.

## Operation
- State machine:
  - LD_IDLE: count=0. SHIFT_EN moves to LD_SHIFT with count=1, except when WIDTH would complete immediately (not possible, because WIDTH>=2).
  - LD_SHIFT: each SHIFT_EN edge increments count. When the WIDTH-th bit is captured, go to LD_IDLE with count=0 and the word complete.
- Shift register behaviour:
  - MSB_FIRST=1: sh <= {sh[WIDTH-2:0], SER}.
  - MSB_FIRST=0: sh <= {SER, sh[WIDTH-1:1]}.
- Completion edge, the edge on which the WIDTH-th bit is captured:
  - If STB=0, or ACK=1 on the same edge: Q <= the assembled word (including the current SER), and STB <= 1.
  - Otherwise: the new word is dropped, Q is unchanged, STB stays 1, and OVR <= 1.
- ACK with STB=1 and no completion on that edge: STB <= 0. ACK with STB=0 is ignored.
- ABORT: count <= 0, state <= LD_IDLE, and the shift register contents become don't-care.
  - ABORT has priority over SHIFT_EN on the same edge, so the SER bit is discarded.
  - ABORT does not touch Q, STB or OVR.
- BUSY = (count != 0), decoded combinationally from state.
- SHIFT_EN=0 in LD_SHIFT holds count and sh indefinitely; there is no timeout.
- Count width is clog2(WIDTH+1). Count never exceeds WIDTH-1 when registered.

## Timing
- Reset values while MR=1: Q=0, STB=0, BUSY=0, OVR=0, state=LD_IDLE, count=0, sh=0.
  - Outputs reach these values asynchronously, without waiting for CP.
- MR deassertion: the first CP rise with MR=0 is a normal functional edge.
- Latency: Q/STB are valid immediately after the CP rise that captures bit WIDTH. This is WIDTH SHIFT_EN edges after the word start, with no extra pipeline stage.
- Back-to-back words: bit 1 of the next word may be captured on the edge after completion. Throughput is one word per WIDTH edges.
- MR mid-word: the partial word is lost; a completed but unacknowledged Q is cleared to 0.

## Structure
- Shared package `common`:
  - loader_state_t enum {LD_IDLE, LD_SHIFT}.
  - Function clog2 if it is not already present.
- One sub-module, serial_byte_loader_shift: shift register plus bit counter.
  - Inputs: CP, MR, SER, SHIFT_EN, ABORT.
  - Outputs: sh, count, done pulse.
- The top level holds the FSM, the Q/STB/OVR output register and the handshake.
- `ifdef FORMAL` block requirements:
  - Assert that MR implies all outputs are 0.
  - Assert that STB stays high until ACK.
  - Assert that Q is stable while STB=1 and ACK=0.
  - Assert that count < WIDTH.
  - Use a reset-aware f_past guard on $past checks.

## Test plan
1. WIDTH=8, MSB_FIRST=1; shift 0,0,0,1,0,0,1,0 on consecutive edges.
   - Expected: Q=8'h12 and STB=1 after the 8th edge.
   - BUSY is 1 after edges 1-7 and 0 after edge 8.
2. Same stream with MSB_FIRST=0.
   - Expected: Q=8'h48.
   - ACK one cycle later gives STB=0, with Q held at 8'h48.
3. Overrun: complete 8'hA5 with no ACK, then complete 8'h3C with no ACK.
   - Expected: Q=8'hA5, STB=1, OVR=1.
   - OVR stays 1 after a later ACK.
4. Simultaneous events:
   - ACK on the completion edge of 8'h3C while holding 8'hA5 gives Q=8'h3C, STB=1, OVR=0.
   - ABORT with SHIFT_EN after 5 bits gives BUSY=0. A following full 8 bits then yields the correct word.
5. Reset: assert MR mid-CP-low after 4 bits, with STB=1 holding 8'hFF.
   - Expected before the next CP edge: Q=0, STB=0, BUSY=0, OVR=0.
   - The next 8 bits after MR release assemble correctly.
